// File: rtl/dlfloat16_fpu_pkg.sv
// Shared opcodes, sign-injection selects, flag positions and controller states
// for the DLFloat16 functional-unit issue path.
package dlfloat16_fpu_pkg;

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SQRT = 4'b0100;
    localparam logic [3:0] OP_SGN  = 4'b0101;

    localparam logic [1:0] SGN_INV = 2'b00;
    localparam logic [1:0] SGN_J   = 2'b01;
    localparam logic [1:0] SGN_JN  = 2'b10;
    localparam logic [1:0] SGN_JX  = 2'b11;

    // Bit positions within the {NV,DZ,OF,UF,NX} flag vector
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/dlfloat16_lat_lookup.sv
// Opcode decode: reports whether a unit exists for the opcode and how many
// cycles its enable must be held.
module dlfloat16_lat_lookup
    import dlfloat16_fpu_pkg::*;
#(
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 8,
    parameter int LAT_SQRT = 8,
    parameter int LAT_SGN  = 1,
    parameter int CNT_W    = 4
) (
    input  logic [3:0]       op,
    output logic             op_valid,
    output logic [CNT_W-1:0] op_lat
);

    always_comb begin
        op_valid = 1'b1;
        op_lat   = '0;
        case (op)
            OP_ADD:  op_lat = CNT_W'(LAT_ADD);
            OP_MUL:  op_lat = CNT_W'(LAT_MUL);
            OP_DIV:  op_lat = CNT_W'(LAT_DIV);
            OP_SQRT: op_lat = CNT_W'(LAT_SQRT);
            OP_SGN:  op_lat = CNT_W'(LAT_SGN);
            default: op_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/dlfloat16_fpu_issue_ctrl.sv
// Issues one DLFloat16 operation at a time to the shared unit bank, waits out
// the unit latency and returns the captured result plus sticky flags.
//
// state | meaning
// IDLE  | ready for a request
// EXEC  | unit enabled, counting down its latency
// CAPT  | enable dropped, sampling the unit's registered result
// RESP  | response held until the consumer takes it
module dlfloat16_fpu_issue_ctrl
    import dlfloat16_fpu_pkg::*;
#(
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 8,
    parameter int LAT_SQRT = 8,
    parameter int LAT_SGN  = 1,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [1:0]  req_sel,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [3:0]  fu_ena,
    output logic [1:0]  fu_sel,
    output logic [15:0] fu_in1,
    output logic [15:0] fu_in2,
    input  logic [31:0] fu_out,
    input  logic [4:0]  fu_exceptions,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [4:0]  rsp_flags,
    output logic        rsp_err,
    output logic [4:0]  fflags,
    input  logic        fflags_clr
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (LAT_ADD < 1 || LAT_ADD > CNT_MAX || LAT_MUL < 1 || LAT_MUL > CNT_MAX ||
        LAT_DIV < 1 || LAT_DIV > CNT_MAX || LAT_SQRT < 1 || LAT_SQRT > CNT_MAX ||
        LAT_SGN < 1 || LAT_SGN > CNT_MAX) begin : g_lat_range_check
        $error("dlfloat16_fpu_issue_ctrl: every LAT_* must be in 1..2**CNT_W-1");
    end

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_valid;
    logic [CNT_W-1:0]   op_lat;

    // The unit bus is 32 bits wide but DLFloat16 results occupy only the low half
    logic fu_out_unused;
    assign fu_out_unused = ^fu_out[31:16];

    dlfloat16_lat_lookup #(
        .LAT_ADD  (LAT_ADD),
        .LAT_MUL  (LAT_MUL),
        .LAT_DIV  (LAT_DIV),
        .LAT_SQRT (LAT_SQRT),
        .LAT_SGN  (LAT_SGN),
        .CNT_W    (CNT_W)
    ) u_lat_lookup (
        .op       (req_op),
        .op_valid (op_valid),
        .op_lat   (op_lat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            fu_ena    <= OP_NONE;
            fu_sel    <= '0;
            fu_in1    <= '0;
            fu_in2    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
            fflags    <= '0;
        end else begin
            // A clear on the handshake edge discards that response's flags
            if (fflags_clr)
                fflags <= '0;
            else if (rsp_valid && rsp_ready)
                fflags <= fflags | rsp_flags;

            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        if (op_valid) begin
                            fu_ena <= req_op;
                            fu_sel <= req_sel;
                            fu_in1 <= req_a;
                            fu_in2 <= req_b;
                            cnt    <= op_lat;
                            state  <= ST_EXEC;
                        end else begin
                            rsp_data  <= '0;
                            rsp_flags <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        fu_ena <= OP_NONE;
                        state  <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    rsp_data  <= fu_out[15:0];
                    rsp_flags <= fu_exceptions;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dlfloat16_fpu_issue_ctrl.sv
// Directed and randomized checks of the DLFloat16 issue controller against a
// transaction-level model of latency, results and sticky flags.
module tb_dlfloat16_fpu_issue_ctrl;
    import dlfloat16_fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [1:0]  req_sel = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic [3:0]  fu_ena;
    logic [1:0]  fu_sel;
    logic [15:0] fu_in1;
    logic [15:0] fu_in2;
    logic [31:0] fu_out = '0;
    logic [4:0]  fu_exceptions = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic [4:0]  rsp_flags;
    logic        rsp_err;
    logic [4:0]  fflags;
    logic        fflags_clr = 1'b0;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [4:0]  model_exc = '0;
    logic [4:0]  model_fflags = '0;

    always #5 clk = ~clk;

    dlfloat16_fpu_issue_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_sel       (req_sel),
        .req_a         (req_a),
        .req_b         (req_b),
        .fu_ena        (fu_ena),
        .fu_sel        (fu_sel),
        .fu_in1        (fu_in1),
        .fu_in2        (fu_in2),
        .fu_out        (fu_out),
        .fu_exceptions (fu_exceptions),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_flags     (rsp_flags),
        .rsp_err       (rsp_err),
        .fflags        (fflags),
        .fflags_clr    (fflags_clr)
    );

    // Toy arithmetic standing in for the unit bank; only its determinism matters
    function automatic logic [15:0] unit_result(input logic [3:0] op, input logic [1:0] sel,
                                                input logic [15:0] a, input logic [15:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_MUL:  return a ^ {b[7:0], b[15:8]};
            OP_DIV:  return a - b;
            OP_SQRT: return {1'b0, a[15:1]};
            OP_SGN: begin
                case (sel)
                    SGN_INV: return {~a[15], a[14:0]};
                    SGN_J:   return {b[15], a[14:0]};
                    SGN_JN:  return {~b[15], a[14:0]};
                    default: return a ^ b;
                endcase
            end
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        case (op)
            OP_ADD:  return 2;
            OP_MUL:  return 3;
            OP_DIV:  return 8;
            OP_SQRT: return 8;
            OP_SGN:  return 1;
            default: return 0;
        endcase
    endfunction

    // Unit bank: registers a result (junk in the upper half) while enabled
    always @(posedge clk) begin
        if (fu_ena != 4'b0000) begin
            fu_out        <= {16'hDEAD, unit_result(fu_ena, fu_sel, fu_in1, fu_in2)};
            fu_exceptions <= model_exc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [1:0] sel, input logic [15:0] a,
                          input logic [15:0] b, input logic [4:0] exc, input int hold,
                          input bit clr);
        bit          valid_op;
        int          lat;
        int          ena_cycles;
        int          n;
        bit          bus_bad;
        bit          ready_bad;
        bit          hold_bad;
        logic [15:0] exp_data;
        logic [4:0]  exp_flags;
        valid_op  = (lat_of(op) != 0);
        lat       = lat_of(op);
        exp_data  = valid_op ? unit_result(op, sel, a, b) : 16'h0000;
        exp_flags = valid_op ? exc : 5'b00000;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        model_exc = exc;
        req_valid = 1'b1;
        req_op    = op;
        req_sel   = sel;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = $urandom_range(0, 15);
        req_a     = $urandom;
        ena_cycles = 0;
        bus_bad    = 1'b0;
        ready_bad  = 1'b0;
        n          = 1;
        while (!rsp_valid && n <= 20) begin
            if (fu_ena != 4'b0000) begin
                ena_cycles++;
                if (fu_ena !== op || fu_sel !== sel || fu_in1 !== a || fu_in2 !== b)
                    bus_bad = 1'b1;
            end
            if (req_ready !== 1'b0) ready_bad = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        check("latency", 32'(n), valid_op ? 32'(lat + 2) : 32'd1);
        check("fu_ena_cycles", 32'(ena_cycles), 32'(lat));
        check("fu_bus", 32'(bus_bad), 32'd0);
        check("req_ready_busy", 32'(ready_bad), 32'd0);
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("rsp_flags", 32'(rsp_flags), 32'(exp_flags));
        check("rsp_err", 32'(rsp_err), valid_op ? 32'd0 : 32'd1);
        check("fu_ena_resp", 32'(fu_ena), 32'd0);
        hold_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_flags !== exp_flags ||
                req_ready !== 1'b0 || fu_ena !== 4'b0000)
                hold_bad = 1'b1;
        end
        if (hold > 0) check("resp_hold", 32'(hold_bad), 32'd0);
        rsp_ready  = 1'b1;
        fflags_clr = clr;
        model_fflags = clr ? 5'b00000 : (model_fflags | exp_flags);
        @(negedge clk);
        rsp_ready  = 1'b0;
        fflags_clr = 1'b0;
        check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
        check("req_ready_after_hs", 32'(req_ready), 32'd1);
        check("fflags", 32'(fflags), 32'(model_fflags));
    endtask

    task automatic clear_pulse();
        fflags_clr = 1'b1;
        @(negedge clk);
        fflags_clr   = 1'b0;
        model_fflags = 5'b00000;
        check("fflags_clr", 32'(fflags), 32'd0);
    endtask

    initial begin
        logic [3:0] op;
        int         pick;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_fu_ena", 32'(fu_ena), 32'd0);
        check("rst_outputs", {rsp_data, 5'(rsp_flags), 1'(rsp_err), 5'(fflags)}, 32'd0);
        @(negedge clk);

        run_op(OP_SGN, SGN_INV, 16'h3E00, 16'h0000, 5'b00000, 0, 1'b0);
        check("sgn_inv_value", 32'(dut.rsp_data), 32'h0000_BE00);
        run_op(OP_SGN, SGN_JX, 16'h8000, 16'hC100, 5'b00000, 5, 1'b0);
        run_op(OP_MUL, 2'b00, 16'h1234, 16'h5678, 5'b00101, 0, 1'b0);
        run_op(OP_ADD, 2'b01, 16'h4000, 16'h3C00, 5'b10000, 1, 1'b0);
        check("fflags_accum", 32'(fflags), 32'h15);
        clear_pulse();
        run_op(4'b1111, 2'b10, 16'hAAAA, 16'h5555, 5'b11111, 0, 1'b0);

        // Reset during the second EXEC cycle of a divide
        model_exc = 5'b01000;
        req_valid = 1'b1;
        req_op    = OP_DIV;
        req_sel   = 2'b00;
        req_a     = 16'h4200;
        req_b     = 16'h3C00;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_fflags = 5'b00000;
        check("rst_exec_fu_ena", 32'(fu_ena), 32'd0);
        check("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_exec_req_ready", 32'(req_ready), 32'd1);
        check("rst_exec_fflags", 32'(fflags), 32'd0);
        @(negedge clk);
        check("rst_exec_idle", 32'({req_ready, rsp_valid, fu_ena}), 32'h20);

        run_op(OP_SQRT, 2'b00, 16'h4400, 16'h0000, 5'b00010, 2, 1'b1);

        for (int k = 0; k < 40; k++) begin
            pick = $urandom_range(0, 7);
            if (pick < 5)       op = 4'(pick + 1);
            else if (pick == 5) op = 4'b1111;
            else if (pick == 6) op = OP_NONE;
            else                op = 4'($urandom_range(6, 15));
            run_op(op, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                   5'($urandom_range(0, 31)), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 9) == 0) clear_pulse();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
